data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder backed by a
// DEPTH x 32-bit register-file memory. Each accepted request waits
// WAIT_CYCLES extra cycles before the access, then presents a response that
// is held until the initiator takes it.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses beyond the
// storage (otherwise upper address bits are ignored and addresses wrap).
// DEPTH must be a power of two in the range 2..64.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          access_err;
  logic [31:0]   merged_word;

  assign word_idx   = addr_q[AW+1:2];
  assign misaligned = (addr_q[1:0] != 2'b00);

`ifdef DMEM_RANGE_CHECK_EN
  assign out_of_range = (addr_q[31:AW+2] != '0);
`else
  // Upper address bits are intentionally dropped so addresses wrap.
  logic unused_upper_addr;
  assign unused_upper_addr = ^addr_q[31:AW+2];
  assign out_of_range      = 1'b0;
`endif

  assign access_err = misaligned | out_of_range;

  // Byte-merge the stored word with the enabled lanes of the store data.
  always_comb begin
    merged_word = mem_q[word_idx];
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) begin
        merged_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake and memory access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_d       = mem_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          rsp_rdata_d = (access_err || wr_q) ? 32'h0 : mem_q[word_idx];
          if (!access_err && wr_q) begin
            mem_d[word_idx] = merged_word;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State, request capture, registered outputs and storage; reset clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_data_mem_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH       = 64;
  localparam int EXP_LAT     = WAIT_CYCLES + 1;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];

  data_mem_responder #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endfunction

  // Reference behaviour: alignment/range rules, byte-lane merge, wraparound.
  function automatic void model_access(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be,
                                       output logic [31:0] rdata, output logic err);
    int unsigned idx;
    logic [31:0] w;
    err = (addr % 4) != 0;
`ifdef DMEM_RANGE_CHECK_EN
    if (addr >= 32'(DEPTH * 4)) err = 1'b1;
`endif
    idx   = (addr / 4) % DEPTH;
    rdata = 32'h0;
    if (!err) begin
      if (wr) begin
        w = model_mem[idx];
        for (int b = 0; b < 4; b++) begin
          if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        model_mem[idx] = w;
      end else begin
        rdata = model_mem[idx];
      end
    end
  endfunction

  // Drives one request, returns the response and the accept-to-valid edge count.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit auto_ack,
                         output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (auto_ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    int lat;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    reset_n   = 1'b0;
    #12;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_data: got rdata=%h err=%b expected 0/0", rsp_rdata, rsp_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    // Request presented immediately after release must be taken at the first edge.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h3C;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_accept: req_ready got %b expected 0 after first edge", req_ready);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = rsp_rdata;
    e = rsp_err;
    checks++;
    if (lat != EXP_LAT || d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_load: lat=%0d rdata=%h err=%b expected lat=%0d rdata=0 err=0",
               lat, d, e, EXP_LAT);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d;
    logic e;
    int lat;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, d, e, lat);
    checks++;
    if (lat != EXP_LAT || e !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL store_10: lat=%0d err=%b rdata=%h expected %0d/0/0", lat, e, d, EXP_LAT);
    end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (lat != EXP_LAT || e !== 1'b0 || d !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL load_10: lat=%0d err=%b rdata=%h expected %0d/0/deadbeef", lat, e, d, EXP_LAT);
    end
    run_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, d, e, lat);
    run_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, d, e, lat);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h11BB33DD) begin
      failures++;
      $display("[TB] FAIL byte_enable: err=%b rdata=%h expected 0/11bb33dd", e, d);
    end
    run_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, d, e, lat);
    checks++;
    if (e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL store_be0_err: got %b expected 0", e);
    end
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (d !== 32'h11BB33DD) begin
      failures++;
      $display("[TB] FAIL store_be0_mem: got %h expected 11bb33dd", d);
    end
    run_txn(1'b0, 32'h06, 32'h0, 4'hF, 1'b1, d, e, lat);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL misaligned_load: err=%b rdata=%h expected 1/0", e, d);
    end
    run_txn(1'b1, 32'h12, 32'h12345678, 4'hF, 1'b1, d, e, lat);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL misaligned_store_mem: got %h expected deadbeef", d);
    end
    run_txn(1'b1, 32'h104, 32'h55, 4'hF, 1'b1, d, e, lat);
    checks++;
`ifdef DMEM_RANGE_CHECK_EN
    if (e !== 1'b1) begin
      failures++;
      $display("[TB] FAIL range_store_err: got %b expected 1", e);
    end
`else
    if (e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_store_err: got %b expected 0", e);
    end
`endif
    run_txn(1'b0, 32'h04, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
`ifdef DMEM_RANGE_CHECK_EN
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL range_word1: got %h expected 0", d);
    end
`else
    if (d !== 32'h55) begin
      failures++;
      $display("[TB] FAIL wrap_word1: got %h expected 55", d);
    end
`endif
    // Bring the model up to date with the directed traffic above.
    model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e);
    model_access(1'b1, 32'h20, 32'h11BB33DD, 4'hF, d, e);
    model_access(1'b1, 32'h104, 32'h55, 4'hF, d, e);
  endtask

  task automatic test_random();
    logic [31:0] d, exp_d, addr, wdata;
    logic e, exp_e, wr;
    logic [3:0] be;
    int lat;
    int sel;
    for (int i = 0; i < 60; i++) begin
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      sel   = $urandom_range(0, 9);
      addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
      if (sel == 1) addr = addr | (32'($urandom_range(1, 255)) << 8);
      if (sel == 2 && i > 0) addr = 32'($urandom_range(0, 7)) << 2;
      model_access(wr, addr, wdata, be, exp_d, exp_e);
      run_txn(wr, addr, wdata, be, 1'b1, d, e, lat);
      checks++;
      if (lat != EXP_LAT || d !== exp_d || e !== exp_e) begin
        failures++;
        $display("[TB] FAIL random_%0d: wr=%b addr=%h be=%b got lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b",
                 i, wr, addr, be, lat, d, e, EXP_LAT, exp_d, exp_e);
      end
    end
    // Read back a handful of words to confirm storage matches the model.
    for (int i = 0; i < 8; i++) begin
      addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      model_access(1'b0, addr, 32'h0, 4'h0, exp_d, exp_e);
      run_txn(1'b0, addr, 32'h0, 4'h0, 1'b1, d, e, lat);
      checks++;
      if (d !== exp_d || e !== exp_e) begin
        failures++;
        $display("[TB] FAIL readback_%0d: addr=%h got %h/%b expected %h/%b", i, addr, d, e, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d, exp_d;
    logic e, exp_e;
    int lat;
    bit bad;
    model_access(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, exp_d, exp_e);
    run_txn(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b1, d, e, lat);
    model_access(1'b0, 32'h30, 32'h0, 4'h0, exp_d, exp_e);
    run_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, d, e, lat);
    checks++;
    if (d !== exp_d || e !== exp_e || lat != EXP_LAT) begin
      failures++;
      $display("[TB] FAIL hold_first: rdata=%h err=%b lat=%0d expected %h/%b/%0d", d, e, lat, exp_d, exp_e, EXP_LAT);
    end
    // Keep a new request pending while the response is stalled.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      bad = (rsp_valid !== 1'b1) || (rsp_rdata !== exp_d) || (rsp_err !== exp_e) || (req_ready !== 1'b0);
      checks++;
      if (bad) begin
        failures++;
        $display("[TB] FAIL hold_cycle_%0d: valid=%b rdata=%h err=%b ready=%b expected 1/%h/%b/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_d, exp_e);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_release: valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    // The stalled store must not have been taken.
    run_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL hold_ignored_req: got %h expected cafef00d", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp_d, addr, wdata;
    logic e, exp_e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      wdata = $urandom;
      model_access(1'(i % 2 == 0), addr, wdata, 4'hF, exp_d, exp_e);
      run_txn(1'(i % 2 == 0), addr, wdata, 4'hF, 1'b1, d, e, lat);
      checks++;
      if (req_ready !== 1'b1 || lat != EXP_LAT || d !== exp_d) begin
        failures++;
        $display("[TB] FAIL b2b_%0d: ready=%b lat=%0d rdata=%h expected 1/%0d/%h", i, req_ready, lat, d, EXP_LAT, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic e;
    int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h08;
    req_wdata = 32'h1;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL midreset_no_rsp: rsp_valid high %0d cycles expected 0", seen);
    end
    run_txn(1'b0, 32'h08, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_load08: got %h/%b expected 0/0", d, e);
    end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, lat);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_mem_cleared: got %h expected 0", d);
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
